// File: rtl/dec_correction_pipe.sv
// dec_correction_pipe
// Two-stage valid/ready pipeline that applies the DEC locator flip vector to a
// received data word. Each word is classified as clean, corrected (1 or 2 bits)
// or uncorrectable. Saturating counters record corrected and uncorrectable
// deliveries. S1 captures the raw fields. S2 holds the classified result and
// drives the out_* ports directly, so the outputs stay stable while stalled.
module dec_correction_pipe #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_flip,
    input  logic              in_ded_a,
    input  logic              in_ded_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_nerr,
    output logic              out_uncorr,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    localparam int PC_W = $clog2(DATA_W + 1);

    // Stage S1 registers
    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_data_q;
    logic [DATA_W-1:0] s1_flip_q;
    logic              s1_ded_q;

    // Stage S2 (output) registers
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [1:0]        out_nerr_q;
    logic              out_uncorr_q;

    // Classification result computed from S1 contents
    logic [DATA_W-1:0] res_data_d;
    logic [1:0]        res_nerr_d;
    logic              res_uncorr_d;
    logic [PC_W-1:0]   flip_pc;

    // Statistics
    logic [CNT_W-1:0]  corr_cnt_q;
    logic [CNT_W-1:0]  corr_cnt_d;
    logic [CNT_W-1:0]  uncorr_cnt_q;
    logic [CNT_W-1:0]  uncorr_cnt_d;

    logic ready_s1;
    logic ready_s2;
    logic out_xfer;

    // Backpressure chain: a stage can load when it is empty or its consumer
    // drains it in the same cycle. in_ready is combinational through the chain.
    assign ready_s2 = !out_valid_q || out_ready;
    assign ready_s1 = !s1_valid_q || ready_s2;
    assign in_ready = ready_s1;
    assign out_xfer = out_valid_q && out_ready;

    // Stage S1: capture the raw word, flip vector and merged DED flag on input transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_flip_q  <= '0;
            s1_ded_q   <= 1'b0;
        end else if (ready_s1) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_data_q <= in_data;
                s1_flip_q <= in_flip;
                s1_ded_q  <= in_ded_a | in_ded_b;
            end
        end
    end

    // Count the bits the locators want to flip
    always_comb begin
        flip_pc = '0;
        for (int i = 0; i < DATA_W; i++) begin
            flip_pc = flip_pc + PC_W'(s1_flip_q[i]);
        end
    end

    // Classify the S1 word. The raw data passes through whenever the word is
    // uncorrectable, so the flip vector is never applied to a bad word.
    always_comb begin
        res_data_d   = s1_data_q;
        res_nerr_d   = 2'd0;
        res_uncorr_d = 1'b0;
        if (s1_ded_q) begin
            res_uncorr_d = 1'b1;
        end else if (flip_pc == '0) begin
            res_uncorr_d = 1'b0;
        end else if (flip_pc <= PC_W'(2)) begin
            res_data_d = s1_data_q ^ s1_flip_q;
            res_nerr_d = flip_pc[1:0];
        end else begin
            res_uncorr_d = 1'b1;
        end
    end

    // Stage S2: register the classified result; hold it while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_nerr_q   <= 2'd0;
            out_uncorr_q <= 1'b0;
        end else if (ready_s2) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q   <= res_data_d;
                out_nerr_q   <= res_nerr_d;
                out_uncorr_q <= res_uncorr_d;
            end
        end
    end

    // Counter next state: clear has priority, increments saturate at all-ones
    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (clr_cnt) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (out_xfer) begin
            if ((out_nerr_q != 2'd0) && (corr_cnt_q != {CNT_W{1'b1}})) begin
                corr_cnt_d = corr_cnt_q + CNT_W'(1);
            end
            if (out_uncorr_q && (uncorr_cnt_q != {CNT_W{1'b1}})) begin
                uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_nerr   = out_nerr_q;
    assign out_uncorr = out_uncorr_q;
    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_dec_correction_pipe.sv
// Directed testbench for dec_correction_pipe. A 16-bit-counter instance is
// checked for the datapath and the statistics. A second instance with 2-bit
// counters shares the same stimulus and is used to check saturation.
module tb_dec_correction_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] in_flip;
    logic        in_ded_a;
    logic        in_ded_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_nerr;
    logic        out_uncorr;
    logic        clr_cnt;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;

    logic        in_ready_s;
    logic        out_valid_s;
    logic [31:0] out_data_s;
    logic [1:0]  out_nerr_s;
    logic        out_uncorr_s;
    logic [1:0]  corr_cnt_s;
    logic [1:0]  uncorr_cnt_s;

    int checks = 0;
    int errors = 0;

    logic [31:0] vec_data [8];
    logic [31:0] vec_flip [8];
    logic        vec_ded  [8];
    logic [31:0] exp_data [8];
    logic [1:0]  exp_nerr [8];
    logic        exp_unc  [8];

    dec_correction_pipe #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_flip(in_flip),
        .in_ded_a(in_ded_a), .in_ded_b(in_ded_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_nerr(out_nerr), .out_uncorr(out_uncorr),
        .clr_cnt(clr_cnt), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    dec_correction_pipe #(.DATA_W(32), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_flip(in_flip),
        .in_ded_a(in_ded_a), .in_ded_b(in_ded_b),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .out_nerr(out_nerr_s), .out_uncorr(out_uncorr_s),
        .clr_cnt(clr_cnt), .corr_cnt(corr_cnt_s), .uncorr_cnt(uncorr_cnt_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one word with the pipe empty and out_ready=1. Capture the outputs
    // after the second edge, then let the transfer edge pass.
    task automatic pipe_one(input logic [31:0] d, input logic [31:0] f,
                            input logic a, input logic b,
                            output logic ov, output logic [31:0] od,
                            output logic [1:0] on, output logic ou);
        in_valid = 1'b1; in_data = d; in_flip = f; in_ded_a = a; in_ded_b = b;
        tick;
        in_valid = 1'b0; in_ded_a = 1'b0; in_ded_b = 1'b0;
        tick;
        ov = out_valid; od = out_data; on = out_nerr; ou = out_uncorr;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_flip = '0;
        in_ded_a = 1'b0; in_ded_b = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_nerr !== 2'd0 || out_uncorr !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h nerr=%0d uncorr=%b, want 0/0/0/0",
                     out_valid, out_data, out_nerr, out_uncorr);
        end
        checks++;
        if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters: corr=%0d uncorr=%0d, want 0/0", corr_cnt, uncorr_cnt);
        end
        tick;
        tick;
        rst = 1'b0;
        tick;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
        $display("reset: outputs and counters checked");
    endtask

    task automatic test_correct;
        logic        ov;
        logic [31:0] od;
        logic [1:0]  on;
        logic        ou;
        // Single-bit correction with an explicit latency check
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'hA5A5_0000; in_flip = 32'h0000_0001;
        tick;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL correct1_early: out_valid=%b after first edge, want 0", out_valid);
        end
        tick;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001 || out_nerr !== 2'd1 || out_uncorr !== 1'b0) begin
            errors++;
            $display("FAIL correct1_out: valid=%b data=%h nerr=%0d uncorr=%b, want 1/a5a50001/1/0",
                     out_valid, out_data, out_nerr, out_uncorr);
        end
        tick;
        checks++;
        if (corr_cnt !== 16'd1 || uncorr_cnt !== 16'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL correct1_cnt: corr=%0d uncorr=%0d valid=%b, want 1/0/0",
                     corr_cnt, uncorr_cnt, out_valid);
        end
        $display("correct: data=a5a50000 flip=00000001 -> %h nerr=%0d corr_cnt=%0d", od, out_nerr, corr_cnt);

        // Double-bit correction
        pipe_one(32'h0000_0000, 32'h0001_0001, 1'b0, 1'b0, ov, od, on, ou);
        checks++;
        if (ov !== 1'b1 || od !== 32'h0001_0001 || on !== 2'd2 || ou !== 1'b0 || corr_cnt !== 16'd2) begin
            errors++;
            $display("FAIL correct2: valid=%b data=%h nerr=%0d uncorr=%b corr=%0d, want 1/00010001/2/0/2",
                     ov, od, on, ou, corr_cnt);
        end
        $display("correct: data=00000000 flip=00010001 -> %h nerr=%0d", od, on);

        // Clean word leaves both counters alone
        pipe_one(32'hCAFE_F00D, 32'h0000_0000, 1'b0, 1'b0, ov, od, on, ou);
        checks++;
        if (ov !== 1'b1 || od !== 32'hCAFE_F00D || on !== 2'd0 || ou !== 1'b0 ||
            corr_cnt !== 16'd2 || uncorr_cnt !== 16'd0) begin
            errors++;
            $display("FAIL clean: valid=%b data=%h nerr=%0d uncorr=%b corr=%0d unc=%0d, want 1/cafef00d/0/0/2/0",
                     ov, od, on, ou, corr_cnt, uncorr_cnt);
        end
        $display("clean: data=cafef00d flip=0 -> %h nerr=%0d uncorr=%b", od, on, ou);
    endtask

    task automatic test_uncorr;
        logic        ov;
        logic [31:0] od;
        logic [1:0]  on;
        logic        ou;
        pipe_one(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b1, ov, od, on, ou);
        checks++;
        if (ov !== 1'b1 || od !== 32'hFFFF_FFFF || on !== 2'd0 || ou !== 1'b1 || uncorr_cnt !== 16'd1) begin
            errors++;
            $display("FAIL uncorr_dedb: valid=%b data=%h nerr=%0d uncorr=%b unc=%0d, want 1/ffffffff/0/1/1",
                     ov, od, on, ou, uncorr_cnt);
        end
        $display("uncorr: ded_b flip=80000001 -> %h uncorr=%b", od, ou);

        pipe_one(32'hFFFF_FFFF, 32'h0000_0007, 1'b0, 1'b0, ov, od, on, ou);
        checks++;
        if (ov !== 1'b1 || od !== 32'hFFFF_FFFF || on !== 2'd0 || ou !== 1'b1 || uncorr_cnt !== 16'd2) begin
            errors++;
            $display("FAIL uncorr_pc3: valid=%b data=%h nerr=%0d uncorr=%b unc=%0d, want 1/ffffffff/0/1/2",
                     ov, od, on, ou, uncorr_cnt);
        end
        $display("uncorr: three flips -> %h uncorr=%b", od, ou);

        pipe_one(32'h0F0F_0F0F, 32'h0000_0001, 1'b1, 1'b0, ov, od, on, ou);
        checks++;
        if (ov !== 1'b1 || od !== 32'h0F0F_0F0F || on !== 2'd0 || ou !== 1'b1 ||
            uncorr_cnt !== 16'd3 || corr_cnt !== 16'd2) begin
            errors++;
            $display("FAIL uncorr_deda: valid=%b data=%h nerr=%0d uncorr=%b unc=%0d corr=%0d, want 1/0f0f0f0f/0/1/3/2",
                     ov, od, on, ou, uncorr_cnt, corr_cnt);
        end
        $display("uncorr: ded_a with flip=1 -> %h uncorr=%b", od, ou);
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h1111_0000; in_flip = 32'h0000_0001;
        tick;
        in_data = 32'h2222_0000;
        tick;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: out_valid=%b before reset, want 1", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_nerr !== 2'd0 ||
            corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midrst_async: valid=%b data=%h nerr=%0d corr=%0d unc=%0d, want all 0",
                     out_valid, out_data, out_nerr, corr_cnt, uncorr_cnt);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 1'b1; in_data = 32'h1234_5678; in_flip = 32'h0000_0100;
        tick;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_early: out_valid=%b one edge after accept, want 0", out_valid);
        end
        tick;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h1234_5778 || out_nerr !== 2'd1) begin
            errors++;
            $display("FAIL midrst_word: valid=%b data=%h nerr=%0d, want 1/12345778/1",
                     out_valid, out_data, out_nerr);
        end
        tick;
        checks++;
        if (out_valid !== 1'b0 || corr_cnt !== 16'd1) begin
            errors++;
            $display("FAIL midrst_after: valid=%b corr=%0d, want 0/1 (no stale words)", out_valid, corr_cnt);
        end
        $display("reset_mid: in-flight discarded, post-reset word %h", 32'h1234_5778);
    endtask

    task automatic test_back_to_back;
        vec_data[0] = 32'h0000_0000; vec_flip[0] = 32'h0000_0001; vec_ded[0] = 1'b0;
        exp_data[0] = 32'h0000_0001; exp_nerr[0] = 2'd1; exp_unc[0] = 1'b0;
        vec_data[1] = 32'h1111_1111; vec_flip[1] = 32'h0000_0000; vec_ded[1] = 1'b0;
        exp_data[1] = 32'h1111_1111; exp_nerr[1] = 2'd0; exp_unc[1] = 1'b0;
        vec_data[2] = 32'h2222_2222; vec_flip[2] = 32'h0000_0003; vec_ded[2] = 1'b0;
        exp_data[2] = 32'h2222_2221; exp_nerr[2] = 2'd2; exp_unc[2] = 1'b0;
        vec_data[3] = 32'h3333_3333; vec_flip[3] = 32'h8000_0000; vec_ded[3] = 1'b0;
        exp_data[3] = 32'hB333_3333; exp_nerr[3] = 2'd1; exp_unc[3] = 1'b0;
        vec_data[4] = 32'h4444_4444; vec_flip[4] = 32'h0000_0007; vec_ded[4] = 1'b0;
        exp_data[4] = 32'h4444_4444; exp_nerr[4] = 2'd0; exp_unc[4] = 1'b1;
        vec_data[5] = 32'h5555_5555; vec_flip[5] = 32'h0000_0001; vec_ded[5] = 1'b1;
        exp_data[5] = 32'h5555_5555; exp_nerr[5] = 2'd0; exp_unc[5] = 1'b1;
        vec_data[6] = 32'h6666_6666; vec_flip[6] = 32'h0000_0400; vec_ded[6] = 1'b0;
        exp_data[6] = 32'h6666_6266; exp_nerr[6] = 2'd1; exp_unc[6] = 1'b0;
        vec_data[7] = 32'h7777_7777; vec_flip[7] = 32'h0001_0000; vec_ded[7] = 1'b0;
        exp_data[7] = 32'h7776_7777; exp_nerr[7] = 2'd1; exp_unc[7] = 1'b0;

        out_ready = 1'b1;
        clr_cnt = 1'b1;
        tick;
        clr_cnt = 1'b0;
        checks++;
        if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin
            errors++;
            $display("FAIL b2b_clear: corr=%0d unc=%0d, want 0/0", corr_cnt, uncorr_cnt);
        end
        for (int t = 0; t < 10; t++) begin
            if (t < 8) begin
                in_valid = 1'b1; in_data = vec_data[t]; in_flip = vec_flip[t];
                in_ded_a = vec_ded[t];
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready[%0d]: in_ready=%b, want 1", t, in_ready);
                end
            end else begin
                in_valid = 1'b0; in_ded_a = 1'b0;
            end
            tick;
            if (t >= 1 && t <= 8) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_data[t-1] ||
                    out_nerr !== exp_nerr[t-1] || out_uncorr !== exp_unc[t-1]) begin
                    errors++;
                    $display("FAIL b2b_out[%0d]: valid=%b data=%h nerr=%0d uncorr=%b, want 1/%h/%0d/%b",
                             t-1, out_valid, out_data, out_nerr, out_uncorr,
                             exp_data[t-1], exp_nerr[t-1], exp_unc[t-1]);
                end
                $display("b2b: word %0d out=%h nerr=%0d uncorr=%b", t-1, out_data, out_nerr, out_uncorr);
            end
        end
        checks++;
        if (out_valid !== 1'b0 || corr_cnt !== 16'd5 || uncorr_cnt !== 16'd2) begin
            errors++;
            $display("FAIL b2b_end: valid=%b corr=%0d unc=%0d, want 0/5/2", out_valid, corr_cnt, uncorr_cnt);
        end
    endtask

    task automatic test_stall;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hAAAA_0000; in_flip = 32'h0000_0000;
        tick;
        in_data = 32'hBBBB_0000; in_flip = 32'h0000_0001;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_ready1: in_ready=%b with one word held, want 1", in_ready);
        end
        tick;
        in_data = 32'hCCCC_0000; in_flip = 32'h0000_0030;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hAAAA_0000 ||
                out_nerr !== 2'd0 || out_uncorr !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: in_ready=%b valid=%b data=%h nerr=%0d, want 0/1/aaaa0000/0",
                         k, in_ready, out_valid, out_data, out_nerr);
            end
            $display("stall: cycle %0d out=%h in_ready=%b", k, out_data, in_ready);
            tick;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: in_ready=%b after out_ready=1, want 1", in_ready);
        end
        tick;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hBBBB_0001 || out_nerr !== 2'd1) begin
            errors++;
            $display("FAIL stall_b: valid=%b data=%h nerr=%0d, want 1/bbbb0001/1", out_valid, out_data, out_nerr);
        end
        tick;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hCCCC_0030 || out_nerr !== 2'd2) begin
            errors++;
            $display("FAIL stall_c: valid=%b data=%h nerr=%0d, want 1/cccc0030/2", out_valid, out_data, out_nerr);
        end
        tick;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain: out_valid=%b, want 0 (no duplicate)", out_valid);
        end
        $display("stall: drained a,b,c in order");
    endtask

    task automatic test_saturate;
        logic        ov;
        logic [31:0] od;
        logic [1:0]  on;
        logic        ou;
        logic [1:0]  want;
        out_ready = 1'b1;
        clr_cnt = 1'b1;
        tick;
        clr_cnt = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            pipe_one(32'h0000_0000, 32'h0000_0001 << k, 1'b0, 1'b0, ov, od, on, ou);
            want = (k >= 3) ? 2'd3 : 2'(k);
            checks++;
            if (corr_cnt_s !== want || uncorr_cnt_s !== 2'd0) begin
                errors++;
                $display("FAIL sat_cnt[%0d]: corr=%0d unc=%0d, want %0d/0", k, corr_cnt_s, uncorr_cnt_s, want);
            end
            $display("saturate: word %0d corr_cnt(2b)=%0d", k, corr_cnt_s);
        end
        in_valid = 1'b1; in_data = 32'h0000_0000; in_flip = 32'h0000_0100;
        tick;
        in_valid = 1'b0;
        tick;
        checks++;
        if (out_valid_s !== 1'b1 || out_nerr_s !== 2'd1) begin
            errors++;
            $display("FAIL clr_pre: valid=%b nerr=%0d, want 1/1", out_valid_s, out_nerr_s);
        end
        clr_cnt = 1'b1;
        tick;
        clr_cnt = 1'b0;
        checks++;
        if (corr_cnt_s !== 2'd0 || corr_cnt !== 16'd0) begin
            errors++;
            $display("FAIL clr_wins: corr(2b)=%0d corr(16b)=%0d, want 0/0", corr_cnt_s, corr_cnt);
        end
        $display("saturate: clear with transfer -> corr_cnt=%0d", corr_cnt_s);
    endtask

    initial begin
        test_reset;
        test_correct;
        test_uncorr;
        test_reset_mid;
        test_back_to_back;
        test_stall;
        test_saturate;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
